// File: rtl/add_sequencer64.sv
// 64-bit adder/subtractor that time-multiplexes a single 16-bit carry-look-ahead
// slice over four cycles, least significant slice first.

module Cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  groupP;
    logic [3:0]  groupG;
    logic [4:0]  groupC;

    // Four 4-bit groups; carries into each group are looked ahead from group generate/propagate.
    always_comb begin
        p = a_i ^ b_i;
        g = a_i & b_i;
        for (int k = 0; k < 4; k++) begin
            groupP[k] = &p[4*k +: 4];
            groupG[k] = g[4*k+3]
                      | (p[4*k+3] & g[4*k+2])
                      | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                      | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        groupC[0] = cin_i;
        groupC[1] = groupG[0] | (groupP[0] & cin_i);
        groupC[2] = groupG[1] | (groupP[1] & groupG[0]) | (groupP[1] & groupP[0] & cin_i);
        groupC[3] = groupG[2] | (groupP[2] & groupG[1]) | (groupP[2] & groupP[1] & groupG[0])
                  | (groupP[2] & groupP[1] & groupP[0] & cin_i);
        groupC[4] = groupG[3] | (groupP[3] & groupG[2]) | (groupP[3] & groupP[2] & groupG[1])
                  | (groupP[3] & groupP[2] & groupP[1] & groupG[0])
                  | (groupP[3] & groupP[2] & groupP[1] & groupP[0] & cin_i);
        for (int k = 0; k < 4; k++) begin
            c[4*k] = groupC[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        sum_o  = p ^ c;
        cout_o = groupC[4];
    end

endmodule

module add_sequencer64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic        sub,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum,
    output logic        cout,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [63:0] opA_q, opA_d;
    logic [63:0] opB_q, opB_d;
    logic [63:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        cout_q, cout_d;
    logic        overflow_q, overflow_d;

    logic [15:0] sliceA;
    logic [15:0] sliceB;
    logic [15:0] sliceSum;
    logic        sliceCout;

    assign sliceA = opA_q[{idx_q, 4'b0000} +: 16];
    assign sliceB = opB_q[{idx_q, 4'b0000} +: 16];

    Cla16 u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Subtraction is a + ~b + 1, so B is inverted and the carry seeded with 1 at accept.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = 2'd0;
                    opA_d   = a;
                    opB_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                end
            end
            RUN: begin
                sum_d[{idx_q, 4'b0000} +: 16] = sliceSum;
                carry_d = sliceCout;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d    = DONE;
                    cout_d     = sliceCout;
                    overflow_d = (opA_q[63] == opB_q[63]) && (sliceSum[15] != opA_q[63]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            opA_q      <= 64'd0;
            opB_q      <= 64'd0;
            sum_q      <= 64'd0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_add_sequencer64.sv
// Directed self-checking bench for add_sequencer64: hand-computed sums, latency,
// busy/done timing, start-while-busy and reset-abort behaviour.

module tb_add_sequencer64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        overflow;

    int checkCount;
    int failCount;

    add_sequencer64 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drives one operation, checks busy every cycle until done, then the result and latency.
    task automatic applyStimulus(input string tag, input logic [63:0] opA, input logic [63:0] opB,
                                 input logic opCin, input logic opSub, input logic [63:0] expSum,
                                 input logic expCout, input logic expOvf);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        cin   = opCin;
        sub   = opSub;
        @(negedge clk);
        start = 1'b0;
        a     = 64'hDEAD_BEEF_0BAD_F00D;
        b     = 64'h0123_4567_89AB_CDEF;
        cycles = 1;
        while (!done && cycles < 10) begin
            checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'd5);
        checkOutput({tag, "_doneBusy"}, 64'(busy), 64'd1);
        checkOutput({tag, "_sum"}, sum, expSum);
        checkOutput({tag, "_cout"}, 64'(cout), 64'(expCout));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expOvf));
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
        checkOutput({tag, "_hold"}, sum, expSum);
    endtask

    initial begin
        int doneSeen;
        checkCount = 0;
        failCount  = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 64'd1;
        b     = 64'd2;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        // Reset held with start high: nothing may be accepted.
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_sum", sum, 64'd0);
        checkOutput("rst_cout", 64'(cout), 64'd0);
        checkOutput("rst_ovf", 64'(overflow), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle", 64'(busy), 64'd0);

        applyStimulus("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        applyStimulus("posOvf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        applyStimulus("subNeg", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        applyStimulus("subOvf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        applyStimulus("slice32", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        applyStimulus("cinOnly", 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0);
        applyStimulus("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
                      64'h2222_2222_2222_2212, 1'b0, 1'b0);

        // Start held high throughout: operands change every cycle but only the accepted pair counts.
        @(negedge clk);
        start = 1'b1;
        a     = 64'd3;
        b     = 64'd4;
        cin   = 1'b0;
        sub   = 1'b0;
        doneSeen = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            a = 64'd100 + 64'(i);
            b = 64'hFFFF_0000_0000_0000 + 64'(i);
            if (done) doneSeen++;
            if (i < 5) checkOutput("hold_busy", 64'(busy), 64'd1);
        end
        checkOutput("hold_doneAt5", 64'(done), 64'd1);
        checkOutput("hold_sum", sum, 64'd7);
        a = 64'd1;
        b = 64'd2;
        @(negedge clk);
        checkOutput("hold_gapIdle", 64'(busy), 64'd0);
        checkOutput("hold_oneDone", 64'(doneSeen), 64'd1);
        @(negedge clk);
        start = 1'b0;
        checkOutput("hold_reaccept", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("hold_second_done", 64'(done), 64'd1);
        checkOutput("hold_second_sum", sum, 64'd3);

        // Reset while idx=2 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a     = 64'h0000_1111_2222_3333;
        b     = 64'h0000_0001_0001_0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_sum", sum, 64'd0);
        checkOutput("abort_cout", 64'(cout), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) doneSeen++;
            @(negedge clk);
        end
        checkOutput("abort_noDone", 64'(doneSeen), 64'd0);
        applyStimulus("afterAbort", 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
